fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the register file.
- Owns R15 advancement: drives PC_in/PCLd into the register file and reads the current PC back from PC_out.
- Issues one instruction-memory request per fetch through a req/ready handshake and presents the fetched word to decode in a one-entry IR register plus a one-entry skid buffer.
- Handles boot load, stall and branch redirect/squash.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded into R15 on the first cycle after reset release.
- PC_STEP, 4, increment applied to the fetch address after a completed fetch.

Ports:
- Clk  in  1  rising-edge clock shared with the register file.
- Reset_n  in  1  asynchronous active-low reset.
- PC_out  in  32  current R15 value from the register file.
- Branch  in  1  single-cycle redirect request from execute.
- Branch_target  in  32  redirect address, valid while Branch=1.
- Stall  in  1  decode cannot accept IR this cycle.
- PC_in  out  32  next-PC value to the register file.
- PCLd  out  1  R15 load enable to the register file.
- Imem_req  out  1  instruction-memory request.
- Imem_addr  out  32  request address.
- Imem_rdata  in  32  instruction word, valid when Imem_ready=1.
- Imem_ready  in  1  memory completes the request this cycle.
- IR  out  32  instruction to decode.
- IR_valid  out  1  IR holds a live instruction.
- IR_pc  out  32  fetch address of IR.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - state=BOOT; IR, IR_pc, Fetch_addr, skid, Target_reg = 0; IR_valid, skid_full, Squash = 0.
  - Imem_req and PCLd drop immediately, including when reset lands mid-WAIT. The outstanding request is abandoned and memory must tolerate this.
- States:
  - BOOT: PCLd=1, PC_in=RESET_PC for exactly one cycle, then ISSUE. Branch is ignored.
  - ISSUE: Imem_req=0. At the edge, if skid_full=0 and Branch=0: Fetch_addr<=PC_out, go to WAIT. Otherwise stay.
  - WAIT: Imem_req=1, Imem_addr=Fetch_addr. Both are held stable until an edge samples Imem_ready=1. Imem_ready is ignored outside WAIT.
- Completed fetch (WAIT, Imem_ready=1, Squash=0, Branch=0):
  - PC_in=Fetch_addr+PC_STEP (mod 2^32), PCLd=1; go to ISSUE.
  - Data goes to IR if the slot frees this edge (IR_valid=0 or Stall=0), else to skid with skid_full<=1.
- IR update at each edge:
  - If Stall=0: skid_full → IR<=skid, skid_full<=0. Else a completed fetch → IR<=rdata. Else IR_valid<=0.
  - If Stall=1: IR and IR_valid hold, unless IR_valid=0, in which case a completed fetch loads IR.
  - IR_pc always travels with its word.
- Branch (priority over Stall and over a completing fetch):
  - In ISSUE: PC_in=Branch_target, PCLd=1; IR_valid<=0, skid_full<=0; stay ISSUE.
  - In WAIT without Imem_ready: Squash<=1, Target_reg<=Branch_target; IR_valid<=0, skid_full<=0.
  - In WAIT with Imem_ready: data discarded; PC_in=Branch_target, PCLd=1; go to ISSUE.
- Squashed completion (WAIT, Imem_ready=1, Squash=1):
  - Data discarded; PC_in=Target_reg, PCLd=1; Squash<=0; go to ISSUE.
  - A Branch in that same cycle overrides Target_reg.
- PCLd is 0 in every case not listed above.
- A register-file data write to R15 on the same edge as PCLd wins inside the register file. The fetch unit sees the result through PC_out at the next ISSUE.
- Peak throughput is one instruction per 2 cycles (ISSUE + single-cycle WAIT).

Optional Feature:
- Macro FETCH_STATS_EN. When defined, adds two outputs:
  - Fetch_count (32): +1 per completed non-squashed fetch.
  - Squash_count (32): +1 per discarded response.
- Both reset to 0 and wrap modulo 2^32.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Boot: release Reset_n, Imem_ready tied 1 → BOOT cycle with PC_in=0, PCLd=1; then Imem_addr sequence 0,4,8; IR=rdata with IR_pc=0,4,8; IR_valid every other cycle.
- Wait states: Imem_ready low for 3 cycles at address 0x10 → Imem_req and Imem_addr=0x10 stable for 4 cycles; PCLd=1 only on the completion cycle with PC_in=0x14.
- Stall/skid: hold Stall=1 with IR_valid=1 while fetch 0x20 completes → word enters skid; no new request issued. Release Stall → IR gets 0x20 word next edge, then fetching resumes at 0x24.
- Branch in WAIT: Branch=1, target 0x100, while fetch 0x30 pending; ready 2 cycles later → response discarded, IR_valid=0, PC_in=0x100 on the completion cycle, next Imem_addr=0x100.
- Branch in ISSUE with skid full: Branch to 0x200 → skid and IR invalidated, PC_in=0x200, PCLd=1; next request at 0x200.
- Reset mid-WAIT: drop Reset_n while Imem_req=1 → Imem_req=0 and IR_valid=0 immediately; after release, BOOT reloads RESET_PC. With FETCH_STATS_EN, counters read 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  fetch_unit_if
//  Fetch-stage bundle: register-file PC path, instruction-memory handshake,
//  decode-side IR port.
//  Revision: 1.0
// ============================================================================
interface fetch_unit_if;
    logic [31:0] PC_out;
    logic        Branch;
    logic [31:0] Branch_target;
    logic        Stall;
    logic [31:0] PC_in;
    logic        PCLd;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic [31:0] Imem_rdata;
    logic        Imem_ready;
    logic [31:0] IR;
    logic        IR_valid;
    logic [31:0] IR_pc;

    modport master (
        input  PC_out, Branch, Branch_target, Stall, Imem_rdata, Imem_ready,
        output PC_in, PCLd, Imem_req, Imem_addr, IR, IR_valid, IR_pc
    );

    modport slave (
        output PC_out, Branch, Branch_target, Stall, Imem_rdata, Imem_ready,
        input  PC_in, PCLd, Imem_req, Imem_addr, IR, IR_valid, IR_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  fetch_unit
//  Instruction fetch: owns R15 advancement, one imem request per fetch,
//  IR + one-entry skid toward decode. FETCH_STATS_EN adds fetch/squash counters.
//  Revision: 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic          Clk,
    input  logic          Reset_n,
    fetch_unit_if.master  bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]   Fetch_count,
    output logic [31:0]   Squash_count
`endif
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] target_q, target_d;
    logic        squash_q, squash_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        skid_full_q, skid_full_d;

    logic        w_pc_ld;
    logic [31:0] w_pc_next;
    logic        w_done;
    logic        w_drop;
    logic        w_kill;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_BOOT;
            fetch_addr_q <= '0;
            target_q     <= '0;
            squash_q     <= 1'b0;
            ir_q         <= '0;
            ir_pc_q      <= '0;
            ir_valid_q   <= 1'b0;
            skid_q       <= '0;
            skid_pc_q    <= '0;
            skid_full_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            target_q     <= target_d;
            squash_q     <= squash_d;
            ir_q         <= ir_d;
            ir_pc_q      <= ir_pc_d;
            ir_valid_q   <= ir_valid_d;
            skid_q       <= skid_d;
            skid_pc_q    <= skid_pc_d;
            skid_full_q  <= skid_full_d;
        end
    end

    // Front end: request sequencing and the PC value handed to R15.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        target_d     = target_q;
        squash_d     = squash_q;
        w_pc_ld      = 1'b0;
        w_pc_next    = fetch_addr_q + PC_STEP;
        w_done       = 1'b0;
        w_drop       = 1'b0;
        w_kill       = 1'b0;
        case (state_q)
            S_BOOT: begin
                w_pc_ld   = 1'b1;
                w_pc_next = RESET_PC;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.Branch) begin
                    w_pc_ld   = 1'b1;
                    w_pc_next = bus.Branch_target;
                    w_kill    = 1'b1;
                end else if (!skid_full_q) begin
                    fetch_addr_d = bus.PC_out;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.Imem_ready) begin
                    w_pc_ld  = 1'b1;
                    state_d  = S_ISSUE;
                    squash_d = 1'b0;
                    if (bus.Branch) begin
                        w_pc_next = bus.Branch_target;
                        w_kill    = 1'b1;
                        w_drop    = 1'b1;
                    end else if (squash_q) begin
                        w_pc_next = target_q;
                        w_drop    = 1'b1;
                    end else begin
                        w_done = 1'b1;
                    end
                end else if (bus.Branch) begin
                    // Response still in flight: remember where to go once it lands.
                    squash_d = 1'b1;
                    target_d = bus.Branch_target;
                    w_kill   = 1'b1;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    // Decode side: IR is the head, skid holds a word that arrived while stalled.
    always_comb begin
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;
        skid_d      = skid_q;
        skid_pc_d   = skid_pc_q;
        skid_full_d = skid_full_q;
        if (w_kill) begin
            ir_valid_d  = 1'b0;
            skid_full_d = 1'b0;
        end else if (!bus.Stall) begin
            if (skid_full_q) begin
                ir_d        = skid_q;
                ir_pc_d     = skid_pc_q;
                ir_valid_d  = 1'b1;
                skid_full_d = 1'b0;
            end else if (w_done) begin
                ir_d       = bus.Imem_rdata;
                ir_pc_d    = fetch_addr_q;
                ir_valid_d = 1'b1;
            end else begin
                ir_valid_d = 1'b0;
            end
        end else if (w_done) begin
            if (!ir_valid_q) begin
                ir_d       = bus.Imem_rdata;
                ir_pc_d    = fetch_addr_q;
                ir_valid_d = 1'b1;
            end else begin
                skid_d      = bus.Imem_rdata;
                skid_pc_d   = fetch_addr_q;
                skid_full_d = 1'b1;
            end
        end
    end

    // Gated by reset so the BOOT load cannot reach R15 while reset is held.
    assign bus.PCLd      = w_pc_ld & Reset_n;
    assign bus.PC_in     = w_pc_next;
    assign bus.Imem_req  = (state_q == S_WAIT);
    assign bus.Imem_addr = fetch_addr_q;
    assign bus.IR        = ir_q;
    assign bus.IR_pc     = ir_pc_q;
    assign bus.IR_valid  = ir_valid_q;

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q;
    logic [31:0] squash_count_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fetch_count_q  <= '0;
            squash_count_q <= '0;
        end else begin
            if (w_done) fetch_count_q  <= fetch_count_q + 32'd1;
            if (w_drop) squash_count_q <= squash_count_q + 32'd1;
        end
    end

    assign Fetch_count  = fetch_count_q;
    assign Squash_count = squash_count_q;
`else
    logic w_unused;
    assign w_unused = w_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  tb_fetch_unit
//  Random stimulus against a queue-based reference of the fetch stage.
//  Revision: 1.0
// ============================================================================
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    logic [31:0] rf_r15;
    logic        rf_wr    = 1'b0;
    logic [31:0] rf_wdata = '0;
    assign bus.PC_out = rf_r15;

    // Register file R15: a data write beats the fetch unit's PC load.
    always @(posedge clk) begin
        if (rf_wr)         rf_r15 <= rf_wdata;
        else if (bus.PCLd) rf_r15 <= bus.PC_in;
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] squash_count;
`endif

    fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
`ifdef FETCH_STATS_EN
        ,
        .Fetch_count  (fetch_count),
        .Squash_count (squash_count)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
    } ent_t;

    // Reference: instructions owed to decode (head = IR), plus front-end status.
    ent_t        dq[$];
    bit          m_boot, m_busy, m_redir;
    logic [31:0] m_addr, m_redir_to, m_r15;
    logic [31:0] m_fetches, m_squashes;

    task automatic model_reset();
        dq.delete();
        m_boot     = 1'b1;
        m_busy     = 1'b0;
        m_redir    = 1'b0;
        m_fetches  = '0;
        m_squashes = '0;
    endtask

    task automatic model_cycle(input bit br, input logic [31:0] tgt, input bit stall,
                               input bit rdy, input bit wr, input logic [31:0] wdata);
        bit          e_ld, done, drop, flush;
        logic [31:0] e_pc;
        ent_t        e;
        e_ld = 1'b0; e_pc = '0; done = 1'b0; drop = 1'b0;
        if (m_boot) begin
            e_ld = 1'b1;
            e_pc = RESET_PC;
        end else if (m_busy && rdy) begin
            e_ld = 1'b1;
            drop = br || m_redir;
            done = !drop;
            e_pc = br ? tgt : (m_redir ? m_redir_to : m_addr + PC_STEP);
        end else if (!m_busy && br) begin
            e_ld = 1'b1;
            e_pc = tgt;
        end

        chk("imem_req", 32'(bus.Imem_req), 32'(m_busy));
        if (m_busy) chk("imem_addr", bus.Imem_addr, m_addr);
        chk("pcld", 32'(bus.PCLd), 32'(e_ld));
        if (e_ld) chk("pc_in", bus.PC_in, e_pc);
        chk("ir_valid", 32'(bus.IR_valid), 32'(dq.size() != 0));
        if (dq.size() != 0) begin
            chk("ir", bus.IR, dq[0].w);
            chk("ir_pc", bus.IR_pc, dq[0].pc);
        end
`ifdef FETCH_STATS_EN
        chk("fetch_count", fetch_count, m_fetches);
        chk("squash_count", squash_count, m_squashes);
`endif

        e.w   = mem_word(m_addr);
        e.pc  = m_addr;
        flush = br && !m_boot;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_busy) begin
            if (rdy) begin
                m_busy  = 1'b0;
                m_redir = 1'b0;
            end else if (br) begin
                m_redir    = 1'b1;
                m_redir_to = tgt;
            end
        end else if (!br && dq.size() < 2) begin
            m_busy = 1'b1;
            m_addr = m_r15;
        end

        if (flush) begin
            dq.delete();
        end else begin
            if (!stall && dq.size() != 0) void'(dq.pop_front());
            if (done) dq.push_back(e);
        end

        if (wr)        m_r15 = wdata;
        else if (e_ld) m_r15 = e_pc;
        if (done) m_fetches  = m_fetches + 32'd1;
        if (drop) m_squashes = m_squashes + 32'd1;
    endtask

    initial begin
        bit          br, stall, rdy, wr, did_rst;
        logic [31:0] tgt, wdata;
        bus.Branch        = 1'b0;
        bus.Branch_target = '0;
        bus.Stall         = 1'b0;
        bus.Imem_ready    = 1'b0;
        bus.Imem_rdata    = '0;
        m_r15   = '0;
        did_rst = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        chk("rst_imem_req", 32'(bus.Imem_req), 32'd0);
        chk("rst_pcld", 32'(bus.PCLd), 32'd0);
        chk("rst_ir_valid", 32'(bus.IR_valid), 32'd0);
        chk("rst_ir", bus.IR, 32'd0);
        chk("rst_ir_pc", bus.IR_pc, 32'd0);
        chk("rst_imem_addr", bus.Imem_addr, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 1500; i++) begin
            if (i < 10) begin
                br = 1'b0; stall = 1'b0; rdy = 1'b1; wr = 1'b0;
            end else begin
                br    = ($urandom % 100) < 8;
                stall = ($urandom % 100) < 30;
                rdy   = ($urandom % 100) < 55;
                wr    = ($urandom % 100) < 2;
            end
            tgt   = 32'($urandom_range(0, 1023)) << 2;
            wdata = 32'($urandom_range(0, 1023)) << 2;

            if (!did_rst && i > 400 && m_busy) begin
                did_rst = 1'b1;
                rf_wr   = 1'b0;
                rst_n   = 1'b0;
                #2;
                chk("midrst_imem_req", 32'(bus.Imem_req), 32'd0);
                chk("midrst_pcld", 32'(bus.PCLd), 32'd0);
                chk("midrst_ir_valid", 32'(bus.IR_valid), 32'd0);
`ifdef FETCH_STATS_EN
                chk("midrst_fetch_count", fetch_count, 32'd0);
                chk("midrst_squash_count", squash_count, 32'd0);
`endif
                model_reset();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end

            bus.Branch        = br;
            bus.Branch_target = tgt;
            bus.Stall         = stall;
            bus.Imem_ready    = rdy;
            bus.Imem_rdata    = rdy ? mem_word(bus.Imem_addr) : $urandom;
            rf_wr             = wr;
            rf_wdata          = wdata;
            #1;
            model_cycle(br, tgt, stall, rdy, wr, wdata);
            @(negedge clk);
        end

        if (!did_rst) chk("midrst_reached", 32'(did_rst), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
